// File: rtl/udm_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udm_bus_arbiter
// Purpose  : Two-master / one-slave arbiter for the 32-bit data memory bus.
//            Shares the test memory / CSR slave between the UDM debug master
//            (m0) and the CPU data master (m1), and routes split-transaction
//            read responses back to the issuing master via an ID FIFO.
// Ports    : clk_i, rst_i (async, active-high)
//            m0_* / m1_*  : master request channels (req/we/addr/be/wdata in,
//                           ack/resp/rdata out)
//            s_*          : slave request channel out, ack/resp/rdata in
// Params   : RESP_FIFO_DEPTH - outstanding-read ID FIFO depth (power of 2, >=2)
// Macro    : UDM_ARB_FIXED_PRIO_EN - when defined, m0 always wins a tie;
//            otherwise ties are resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module udm_bus_arbiter #(
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_i
);

    localparam int             c_ptr_w     = $clog2(RESP_FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_fifo_full = (c_ptr_w + 1)'(RESP_FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic                       r_grant, w_grant_nxt;
    logic [RESP_FIFO_DEPTH-1:0] r_id_fifo;
    logic [c_ptr_w-1:0]         r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]           r_count;

    logic w_fifo_full, w_fifo_empty;
    logic w_m0_elig, w_m1_elig, w_tie_winner;
    logic w_sel_req, w_sel_we;
    logic w_accept, w_push, w_pop, w_head_id;

    // Eligibility looks at the registered count only, so a pop in the same
    // cycle never frees a slot for a read grant until the next cycle.
    assign w_fifo_full  = (r_count == c_fifo_full);
    assign w_fifo_empty = (r_count == '0);
    assign w_m0_elig    = m0_req_i & (m0_we_i | ~w_fifo_full);
    assign w_m1_elig    = m1_req_i & (m1_we_i | ~w_fifo_full);

`ifdef UDM_ARB_FIXED_PRIO_EN
    // Debug master preempts the core at every arbitration point.
    assign w_tie_winner = 1'b0;
`else
    logic r_last;

    // The master that was not granted last wins a tie; resets to 1 so m0
    // takes the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= r_grant;
        end
    end

    assign w_tie_winner = ~r_last;
`endif

    assign w_sel_req = r_grant ? m1_req_i : m0_req_i;
    assign w_sel_we  = r_grant ? m1_we_i  : m0_we_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_m0_elig | w_m1_elig) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = (w_m0_elig & w_m1_elig) ? w_tie_winner : w_m1_elig;
                end
            end
            S_BUSY: begin
                if (!w_sel_req) begin
                    // Master withdrew its request before the slave took it.
                    w_state_nxt = S_IDLE;
                end else if (s_ack_i) begin
                    w_state_nxt = S_IDLE;
                    w_accept    = 1'b1;
                    w_push      = ~w_sel_we;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign m0_ack_o = w_accept & ~r_grant;
    assign m1_ack_o = w_accept &  r_grant;

    // Slave channel: granted master in BUSY, all zero in IDLE.
    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (r_state == S_BUSY) begin
            s_req_o = w_sel_req;
            s_we_o  = w_sel_we;
            if (r_grant) begin
                s_addr_o  = m1_addr_i;
                s_be_o    = m1_be_i;
                s_wdata_o = m1_wdata_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_be_o    = m0_be_i;
                s_wdata_o = m0_wdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read ID FIFO and response routing
    // ------------------------------------------------------------------
    assign w_pop     = s_resp_i & ~w_fifo_empty;
    assign w_head_id = r_id_fifo[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id_fifo <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_id_fifo[r_wr_ptr] <= r_grant;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Only resp is steered; both masters see the slave read data.
    assign m0_resp_o  = w_pop & ~w_head_id;
    assign m1_resp_o  = w_pop &  w_head_id;
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;

endmodule
`default_nettype wire
